// File: rtl/packet_injector_mux.sv
// Merges N_CH credit-based flit streams into one link, locking the output to a channel for a whole packet.
// Define INJECTOR_STATS_EN to instantiate per-channel forwarded-packet counters on pkt_cnt_o.
module packet_injector_mux #(
  parameter int N_CH      = 2,
  parameter int FLIT_SIZE = 32,
  parameter int BUF_DEPTH = 4,
  localparam int GW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [N_CH-1:0]                 src_rx_i,
  output logic [N_CH-1:0]                 src_credit_o,
  input  logic [N_CH-1:0][FLIT_SIZE-1:0]  src_data_i,
  output logic                            tx_o,
  input  logic                            credit_i,
  output logic [FLIT_SIZE-1:0]            data_o,
  output logic [GW-1:0]                   grant_o,
  output logic                            busy_o,
  output logic [N_CH-1:0][31:0]           pkt_cnt_o
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a flit moves on a rising edge only when valid (src_rx_i / tx_o)
  // and credit (src_credit_o / credit_i) are both high in that cycle.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_SIZE    = 2'd2,
    S_PAYLOAD = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [GW-1:0]          grant_nxt, last_q, last_nxt;
  logic [FLIT_SIZE-1:0]   cnt_q, cnt_nxt;
  logic                   xfer, pkt_done;
  logic [N_CH-1:0]        wr_en, rd_en, empty;
  logic [FLIT_SIZE-1:0]   head [N_CH];
  logic [GW-1:0]          pick;
  int                     off, best_off;

  for (genvar c = 0; c < N_CH; c++) begin : g_fifo
    logic [FLIT_SIZE-1:0] mem [BUF_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count, count_nxt;
    logic                 credit_q;

    assign wr_en[c]        = src_rx_i[c] && credit_q;
    assign rd_en[c]        = tx_o && credit_i && (grant_o == GW'(c));
    assign empty[c]        = (count == '0);
    assign head[c]         = mem[rd_ptr];
    assign src_credit_o[c] = credit_q;

    always_comb begin
      count_nxt = count;
      if (wr_en[c] && !rd_en[c]) begin
        count_nxt = count + CW'(1);
      end else if (!wr_en[c] && rd_en[c]) begin
        count_nxt = count - CW'(1);
      end
    end

    // Credit is registered from the next occupancy so credit_i never reaches src_credit_o combinationally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        credit_q <= 1'b0;
      end else begin
        if (wr_en[c]) wr_ptr <= wr_ptr + AW'(1);
        if (rd_en[c]) rd_ptr <= rd_ptr + AW'(1);
        count    <= count_nxt;
        credit_q <= (count_nxt != CW'(BUF_DEPTH));
      end
    end

    always_ff @(posedge clk_i) begin
      if (wr_en[c]) mem[wr_ptr] <= src_data_i[c];
    end
  end

  assign tx_o   = (state != S_IDLE) && !empty[grant_o];
  assign data_o = tx_o ? head[grant_o] : '0;
  assign busy_o = (state != S_IDLE);
  assign xfer   = tx_o && credit_i;

  // Round-robin: the channel with the smallest distance above last_q wins.
  always_comb begin
    best_off = N_CH;
    off      = 0;
    pick     = '0;
    for (int c = 0; c < N_CH; c++) begin
      off = (c + N_CH - 1 - int'(last_q)) % N_CH;
      if (!empty[c] && (off < best_off)) begin
        best_off = off;
        pick     = GW'(c);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_o;
    last_nxt  = last_q;
    cnt_nxt   = cnt_q;
    pkt_done  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (best_off < N_CH) begin
          grant_nxt = pick;
          last_nxt  = pick;
          state_nxt = S_HEADER;
        end
      end
      S_HEADER: begin
        if (xfer) state_nxt = S_SIZE;
      end
      S_SIZE: begin
        if (xfer) begin
          cnt_nxt = data_o;
          if (data_o == '0) begin
            state_nxt = S_IDLE;
            pkt_done  = 1'b1;
          end else begin
            state_nxt = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          cnt_nxt = cnt_q - FLIT_SIZE'(1);
          if (cnt_q == FLIT_SIZE'(1)) begin
            state_nxt = S_IDLE;
            pkt_done  = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= S_IDLE;
      grant_o <= '0;
      last_q  <= GW'(N_CH - 1);
      cnt_q   <= '0;
    end else begin
      state   <= state_nxt;
      grant_o <= grant_nxt;
      last_q  <= last_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

`ifdef INJECTOR_STATS_EN
  logic [N_CH-1:0][31:0] stat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (pkt_done && (grant_o == GW'(c))) stat_q[c] <= stat_q[c] + 32'd1;
      end
    end
  end

  assign pkt_cnt_o = stat_q;
`else
  logic stats_unused;
  assign stats_unused = pkt_done;
  assign pkt_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_packet_injector_mux.sv
// Bench for packet_injector_mux: queue-level reference model of sources, FIFOs and packet arbitration.
module tb_packet_injector_mux;
  localparam int N_CH      = 3;
  localparam int FLIT_SIZE = 32;
  localparam int BUF_DEPTH = 4;
  localparam int GW        = 2;

  logic                           clk = 1'b0;
  logic                           rst_ni = 1'b0;
  logic [N_CH-1:0]                src_rx = '0;
  logic [N_CH-1:0]                src_credit;
  logic [N_CH-1:0][FLIT_SIZE-1:0] src_data = '0;
  logic                           tx;
  logic                           credit = 1'b0;
  logic [FLIT_SIZE-1:0]           data;
  logic [GW-1:0]                  grant;
  logic                           busy;
  logic [N_CH-1:0][31:0]          pkt_cnt;

  always #5 clk = ~clk;

  packet_injector_mux #(.N_CH(N_CH), .FLIT_SIZE(FLIT_SIZE), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .src_rx_i(src_rx), .src_credit_o(src_credit),
    .src_data_i(src_data), .tx_o(tx), .credit_i(credit), .data_o(data),
    .grant_o(grant), .busy_o(busy), .pkt_cnt_o(pkt_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: what each source still has to send, what sits in each FIFO,
  // and which packet currently owns the link.
  logic [FLIT_SIZE-1:0] src_q  [N_CH][$];
  logic [FLIT_SIZE-1:0] fifo_q [N_CH][$];
  logic [31:0]          m_stats [N_CH];
  bit                   m_busy;
  int                   m_grant, m_last;
  longint               m_done, m_len;
  bit                   m_len_known;
  int                   valid_pct, credit_pct, cyc;
  bit                   credit_pat_en, saw_full0;
  logic [3:0]           pat = 4'b1001;
  int                   obs_grant_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      src_q[c].delete();
      fifo_q[c].delete();
      m_stats[c] = '0;
    end
    m_busy = 0; m_grant = 0; m_last = N_CH - 1;
    m_done = 0; m_len = 0; m_len_known = 0;
    src_rx = '0; credit = 1'b0;
  endtask

  task automatic send_pkt(input int c, input logic [FLIT_SIZE-1:0] hdr, input int p, input bit rnd);
    src_q[c].push_back(hdr);
    src_q[c].push_back(FLIT_SIZE'(p));
    for (int i = 0; i < p; i++) src_q[c].push_back(rnd ? FLIT_SIZE'($urandom) : FLIT_SIZE'(10 + i));
  endtask

  function automatic bit pending();
    bit any = 0;
    for (int c = 0; c < N_CH; c++) if (src_q[c].size() > 0 || fifo_q[c].size() > 0) any = 1;
    return any;
  endfunction

  // One clock: compare outputs at the falling edge, drive inputs, then advance the model
  // across the next rising edge using the pre-edge occupancy for reads and arbitration.
  task automatic cycle();
    int  nxt;
    bit  found;
    logic [FLIT_SIZE-1:0] f;
    @(negedge clk);
    cyc++;
    check_eq("busy", busy, m_busy);
    for (int c = 0; c < N_CH; c++) begin
      check_eq("src_credit", src_credit[c], fifo_q[c].size() < BUF_DEPTH);
`ifdef INJECTOR_STATS_EN
      check_eq("pkt_cnt", pkt_cnt[c], m_stats[c]);
`else
      check_eq("pkt_cnt_off", pkt_cnt[c], 0);
`endif
    end
    if (m_busy) begin
      check_eq("grant", grant, m_grant);
      check_eq("tx", tx, fifo_q[m_grant].size() > 0);
      if (fifo_q[m_grant].size() > 0) check_eq("data", data, fifo_q[m_grant][0]);
    end else begin
      check_eq("tx_idle", tx, 0);
    end
    if (!src_credit[0]) saw_full0 = 1;

    credit = credit_pat_en ? pat[cyc % 4] : ($urandom_range(0, 99) < credit_pct);
    for (int c = 0; c < N_CH; c++) begin
      if (src_q[c].size() > 0 && $urandom_range(0, 99) < valid_pct) begin
        src_rx[c] = 1'b1; src_data[c] = src_q[c][0];
      end else begin
        src_rx[c] = 1'b0; src_data[c] = $urandom;
      end
    end
    if (tx && credit) obs_grant_q.push_back(int'(grant));

    if (m_busy) begin
      if (fifo_q[m_grant].size() > 0 && credit) begin
        f = fifo_q[m_grant].pop_front();
        m_done++;
        if (m_done == 2) begin m_len = longint'(f) + 2; m_len_known = 1; end
        if (m_len_known && m_done == m_len) begin
          m_busy = 0;
          m_stats[m_grant] = m_stats[m_grant] + 32'd1;
        end
      end
    end else begin
      found = 0;
      for (int k = 1; k <= N_CH; k++) begin
        nxt = (m_last + k) % N_CH;
        if (!found && fifo_q[nxt].size() > 0) begin
          found = 1; m_busy = 1; m_grant = nxt; m_last = nxt;
          m_done = 0; m_len_known = 0;
        end
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      if (src_rx[c] && src_credit[c]) begin
        fifo_q[c].push_back(src_data[c]);
        void'(src_q[c].pop_front());
      end
    end
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n = 0;
    while ((pending() || m_busy) && n < max_cyc) begin
      cycle();
      n++;
    end
    check_eq(tag, pending() || m_busy, 0);
    repeat (2) cycle();
  endtask

  task automatic check_order(input string tag, input int exp_q[$]);
    check_eq({tag, "_len"}, obs_grant_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_grant_q.size(); i++)
      check_eq(tag, obs_grant_q[i], exp_q[i]);
  endtask

  initial begin
    int exp_q[$];
    model_reset();
    cyc = 0; credit_pat_en = 0; saw_full0 = 0;

    // Reset values while rst_ni is held low.
    #1;
    check_eq("rst_tx", tx, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_data", data, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_credit", src_credit, 0);
    check_eq("rst_pkt_cnt", pkt_cnt, 0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;

    // Single packet on ch0 with the link always ready.
    valid_pct = 100; credit_pct = 100;
    obs_grant_q.delete();
    src_q[0].push_back(32'h0101); src_q[0].push_back(32'd3);
    src_q[0].push_back(32'hA); src_q[0].push_back(32'hB); src_q[0].push_back(32'hC);
    drain("single_drain", 50);
    exp_q = '{0, 0, 0, 0, 0};
    check_order("single_order", exp_q);

    // Two back-to-back zero-size packets on ch1.
    obs_grant_q.delete();
    send_pkt(1, 32'h0202, 0, 0);
    send_pkt(1, 32'h0203, 0, 0);
    drain("zero_drain", 50);
    exp_q = '{1, 1, 1, 1};
    check_order("zero_order", exp_q);

    // Contention: two 4-flit packets each on ch0 and ch1 must alternate whole packets.
    obs_grant_q.delete();
    send_pkt(0, 32'h1000, 2, 1); send_pkt(0, 32'h1001, 2, 1);
    send_pkt(1, 32'h2000, 2, 1); send_pkt(1, 32'h2001, 2, 1);
    drain("cont_drain", 100);
    exp_q = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    check_order("cont_order", exp_q);

    // Backpressure with credit pattern 1,0,0,1 fills the ch0 FIFO.
    obs_grant_q.delete();
    credit_pat_en = 1; saw_full0 = 0;
    send_pkt(0, 32'h3000, 6, 1);
    drain("bp_drain", 100);
    credit_pat_en = 0;
    check_eq("bp_full_seen", saw_full0, 1);
    check_eq("bp_flits", obs_grant_q.size(), 8);

    // Underrun: ch0 stalls after its size flit while ch1 has a packet ready.
    obs_grant_q.delete();
    src_q[0].push_back(32'h4000); src_q[0].push_back(32'd3);
    repeat (2) cycle();
    send_pkt(1, 32'h5000, 1, 1);
    repeat (12) cycle();
    check_eq("ur_grant_held", grant, 0);
    check_eq("ur_busy_held", busy, 1);
    for (int i = 0; i < 3; i++) src_q[0].push_back(FLIT_SIZE'($urandom));
    drain("ur_drain", 100);
    exp_q = '{0, 0, 0, 0, 0, 1, 1, 1};
    check_order("ur_order", exp_q);

    // Asynchronous reset in the middle of a long ch0 payload.
    send_pkt(0, 32'h6000, 10, 1);
    repeat (7) cycle();
    #2 rst_ni = 1'b0;
    #1;
    check_eq("arst_tx", tx, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_credit", src_credit, 0);
    check_eq("arst_grant", grant, 0);
    check_eq("arst_pkt_cnt", pkt_cnt, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    obs_grant_q.delete();
    send_pkt(0, 32'h7000, 2, 1);
    drain("arst_after_drain", 50);
    exp_q = '{0, 0, 0, 0};
    check_order("arst_after_order", exp_q);

    // Randomised traffic on all channels with random valid and credit.
    valid_pct = 70; credit_pct = 70;
    for (int i = 0; i < 40; i++)
      send_pkt($urandom_range(0, N_CH - 1), FLIT_SIZE'($urandom), $urandom_range(0, 6), 1);
    drain("rand_drain", 5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/packet_injector_mux.md
Name: packet_injector_mux

Overview:
- Parametrised successor to the single-stream task injector path.
- Merges N_CH independent credit-based packet sources into one credit-based link, e.g. the MA and application injectors feeding a single many-core injection port.
- Each channel has an input FIFO. A round-robin arbiter locks the output to one channel for a whole packet.
- Packet boundaries come from the size flit, so packets are never interleaved.

Parameters:
- N_CH, 2: number of source channels (≥1).
- FLIT_SIZE, 32: flit width in bits.
- BUF_DEPTH, 4: per-channel FIFO depth in flits (power of 2, ≥2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- src_rx_i  in  [N_CH]  per-channel flit valid.
- src_credit_o  out  [N_CH]  per-channel ready (FIFO not full).
- src_data_i  in  [N_CH][FLIT_SIZE]  per-channel flit.
- tx_o  out  1  output flit valid.
- credit_i  in  1  downstream ready.
- data_o  out  FLIT_SIZE  output flit.
- grant_o  out  $clog2(N_CH) (min 1)  channel currently owning the output.
- busy_o  out  1  high while a packet is in flight (state ≠ IDLE).
- pkt_cnt_o  out  [N_CH][32]  packets forwarded per channel (see Optional Feature).

Behaviour:
- Clocking and reset: one clock, clk_i (rising edge). Reset rst_ni is asynchronous and active-low.
- Reset values: all FIFOs empty, state IDLE, grant_o=0, last-grant pointer=N_CH-1, payload counter=0. Outputs: tx_o=0, data_o=0, busy_o=0, pkt_cnt_o=0, src_credit_o=0 while rst_ni=0 and all-ones from the first cycle after release.
- Handshake (both sides): a flit transfers on a rising edge where valid and credit are both 1. No other combination moves data. data_o is stable while tx_o=1 and credit_i=0.
- Input side: src_credit_o[c] = !full[c], registered from FIFO state only, with no combinational path from credit_i. Simultaneous write and read of a full FIFO is not allowed (credit is already 0). Simultaneous write and read of a non-full FIFO keeps the count unchanged.
- Packet format: flit 0 = header (target). Flit 1 = payload size P (full FLIT_SIZE unsigned). Then P payload flits. Total P+2 flits.
- FSM:
  - IDLE: if any FIFO is non-empty, grant the first non-empty channel searching upward from last+1 with wrap-around. Register grant_o, set last=grant, go to HEADER. If none, stay in IDLE.
  - HEADER: tx_o = !empty[grant]. On transfer, go to SIZE.
  - SIZE: tx_o = !empty[grant]. On transfer, load counter with the flit value. If P=0, go to IDLE; else go to PAYLOAD.
  - PAYLOAD: tx_o = !empty[grant]. On transfer, decrement the counter. The transfer with counter=1 goes to IDLE.
- Latency: a flit written into an empty FIFO at edge t with the FSM in IDLE gives tx_o=1 in the cycle after edge t+1. There is one IDLE cycle between consecutive packets.
- Source underrun mid-packet: tx_o drops to 0 and the grant is held. No other channel may take the output until the packet completes.
- Arbitration fairness: a channel that has just completed a packet has the lowest priority at the next IDLE.
- Counter width: FLIT_SIZE bits. P=2^FLIT_SIZE-1 is legal and is counted exactly.
- Reset mid-packet: everything returns to reset values immediately and any partial packet is discarded.

Optional Feature:
- Macro: INJECTOR_STATS_EN.
- Defined: pkt_cnt_o[c] increments by 1 on the final flit transfer of each packet forwarded from channel c (the SIZE transfer when P=0, otherwise the PAYLOAD transfer with counter=1). The counter wraps modulo 2^32.
- Not defined: pkt_cnt_o is tied to 0 and no counter flops are instantiated.

Test Plan:
- Single packet: channel 0 sends {0x0101, 3, A, B, C} with credit_i=1 → data_o emits the same 5 flits on consecutive cycles, grant_o=0, busy_o falls after C, pkt_cnt_o[0]=1 when stats are enabled.
- Zero-size packet: ch1 sends {0x0202, 0} → exactly 2 flits out, FSM returns to IDLE, the next packet header appears after a single IDLE cycle.
- Contention: ch0 and ch1 each queue two 4-flit packets before release → output order is ch0, ch1, ch0, ch1, with no interleaved flits inside any packet.
- Backpressure: credit_i toggles 1,0,0,1 during payload → data_o is held while credit_i=0, no flit is lost or duplicated, and src_credit_o[0] drops to 0 once the FIFO holds BUF_DEPTH=4 flits.
- Underrun: ch0 stalls after its size flit while ch1 has a full packet queued → tx_o=0 and grant_o stays 0 until ch0 finishes; ch1 follows afterwards.
- Async reset mid-payload: assert rst_ni low between clock edges → tx_o=0, busy_o=0, and all FIFOs empty immediately. After release, a new ch0 packet is forwarded correctly.
